// File: rtl/fb_write_sched.sv
// Write-port scheduler for the frame buffer RAM: arbitrates capture, overlay
// and clear-engine writes, and runs the clear-then-resync-on-vsync sequence.
module fb_write_sched #(
  parameter int   DEPTH     = 192000,
  parameter int   AW        = 18,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic          dotclk,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          clear_req,
  input  logic          cap_valid,
  input  logic [AW-1:0] cap_addr,
  input  logic          cap_pixel,
  input  logic          ovl_valid,
  input  logic [AW-1:0] ovl_addr,
  input  logic          ovl_pixel,
  output logic          ovl_ready,
  output logic [AW-1:0] waddr,
  output logic          wdata,
  output logic          wren,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_NORMAL = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] clr_ctr_q, clr_ctr_d;
  logic          vsync_q;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wdata_q, wdata_d;
  logic          wren_q, wren_d;
  logic          busy_q;
  logic [7:0]    drop_q, drop_d;
  logic          drop_inc;
  logic          cap_in_range, ovl_in_range, vsync_rise;

  // Widened compare so the bound still works if DEPTH ever equals 2**AW.
  assign cap_in_range = {1'b0, cap_addr} < DEPTH_W;
  assign ovl_in_range = {1'b0, ovl_addr} < DEPTH_W;
  assign vsync_rise   = vsync & ~vsync_q;

  assign ovl_ready = reset_n & (state_q == ST_NORMAL) & ~cap_valid & ~clear_req;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    clr_ctr_d = clr_ctr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wren_d    = 1'b0;
    drop_inc  = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wren_d   = 1'b1;
        waddr_d  = clr_ctr_q;
        wdata_d  = CLEAR_VAL;
        drop_inc = cap_valid;
        if (clear_req) begin
          clr_ctr_d = '0;
        end else if (clr_ctr_q == LAST_ADDR) begin
          state_d   = ST_SETTLE;
          clr_ctr_d = '0;
        end else begin
          clr_ctr_d = clr_ctr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        drop_inc = cap_valid;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_ctr_d = '0;
        end else if (vsync_rise) begin
          state_d = ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_ctr_d = '0;
          drop_inc  = cap_valid;
        end else if (cap_valid) begin
          if (cap_in_range) begin
            wren_d  = 1'b1;
            waddr_d = cap_addr;
            wdata_d = cap_pixel;
          end else begin
            drop_inc = 1'b1;
          end
        end else if (ovl_valid && ovl_in_range) begin
          wren_d  = 1'b1;
          waddr_d = ovl_addr;
          wdata_d = ovl_pixel;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ctr_d = '0;
        drop_inc  = cap_valid;
      end
    endcase

    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge dotclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_ctr_q <= '0;
      vsync_q   <= 1'b1;
      waddr_q   <= '0;
      wdata_q   <= 1'b0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b1;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      clr_ctr_q <= clr_ctr_d;
      vsync_q   <= vsync;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
      busy_q    <= (state_d != ST_NORMAL);
      drop_q    <= drop_d;
    end
  end

  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wren     = wren_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched, built with a reduced DEPTH so every
// scenario, including several full clears, stays short.
module tb_fb_write_sched;

  localparam int   DEPTH     = 1200;
  localparam int   AW        = 18;
  localparam logic CLEAR_VAL = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  logic          dotclk = 1'b0;
  logic          reset_n, vsync, clear_req;
  logic          cap_valid, cap_pixel, ovl_valid, ovl_pixel;
  logic [AW-1:0] cap_addr, ovl_addr;
  logic          ovl_ready, wdata, wren, busy;
  logic [AW-1:0] waddr;
  logic [7:0]    drop_cnt;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_drop = 0;

  fb_write_sched #(.DEPTH(DEPTH), .AW(AW), .CLEAR_VAL(CLEAR_VAL)) dut (
    .dotclk   (dotclk),
    .reset_n  (reset_n),
    .vsync    (vsync),
    .clear_req(clear_req),
    .cap_valid(cap_valid),
    .cap_addr (cap_addr),
    .cap_pixel(cap_pixel),
    .ovl_valid(ovl_valid),
    .ovl_addr (ovl_addr),
    .ovl_pixel(ovl_pixel),
    .ovl_ready(ovl_ready),
    .waddr    (waddr),
    .wdata    (wdata),
    .wren     (wren),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 dotclk = ~dotclk;

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic push(input int addr, input logic data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one edge; a write expected for this edge must be on the port now,
  // and with nothing expected wren must be low.
  task automatic step();
    wr_t e;
    @(posedge dotclk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      if (wren !== 1'b0) begin
        n_fail++;
        $display("FAIL wren_idle: got wren=%b addr=%0d, expected wren=0", wren, waddr);
      end
    end else begin
      e = exp_q.pop_front();
      if (wren !== 1'b1 || waddr !== e.addr || wdata !== e.data) begin
        n_fail++;
        $display("FAIL write: got wren=%b addr=%0d data=%b, expected wren=1 addr=%0d data=%b",
                 wren, waddr, wdata, e.addr, e.data);
      end
    end
  endtask

  task automatic check_drop(input string name);
    n_checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      n_fail++;
      $display("FAIL %s: got drop_cnt=%0d, expected %0d", name, drop_cnt, exp_drop);
    end
  endtask

  // Finish a clear from address 'from', settle, and enter NORMAL on a vsync rise.
  task automatic go_normal(input int from);
    for (int i = from; i < DEPTH; i++) begin
      push(i, CLEAR_VAL);
      step();
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_settle: got %b, expected 1", busy);
    end
    repeat (3) step();
    vsync = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_vsync_low: got %b, expected 1", busy);
    end
    vsync = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_normal: got %b, expected 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vsync = 1'b1; clear_req = 1'b0;
    cap_valid = 1'b0; cap_addr = '0; cap_pixel = 1'b0;
    ovl_valid = 1'b0; ovl_addr = '0; ovl_pixel = 1'b0;
    repeat (3) step();
    n_checks++;
    if (waddr !== '0 || wdata !== 1'b0 || busy !== 1'b1 || drop_cnt !== 8'd0 || ovl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got waddr=%0d wdata=%b busy=%b drop=%0d ovl_ready=%b, expected 0 0 1 0 0",
               waddr, wdata, busy, drop_cnt, ovl_ready);
    end
  endtask

  task automatic test_clear_settle();
    reset_n = 1'b1;
    go_normal(0);
  endtask

  task automatic test_capture();
    int a;
    cap_valid = 1'b1; cap_addr = AW'(800); cap_pixel = 1'b1;
    push(800, 1'b1);
    step();
    cap_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      cap_valid = 1'b1; cap_addr = AW'(a); cap_pixel = 1'($urandom);
      push(a, cap_pixel);
      step();
    end
    cap_addr = AW'(DEPTH - 1); cap_pixel = 1'b1;
    push(DEPTH - 1, 1'b1);
    step();
    cap_valid = 1'b0;
    step();
    check_drop("drop_after_capture");
  endtask

  task automatic test_back_to_back();
    ovl_valid = 1'b1; ovl_addr = AW'(500); ovl_pixel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_addr = AW'(10 + i); cap_pixel = 1'(i);
      #1;
      n_checks++;
      if (ovl_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ovl_ready_blocked: got %b, expected 0", ovl_ready);
      end
      push(10 + i, 1'(i));
      step();
    end
    cap_valid = 1'b0;
    #1;
    n_checks++;
    if (ovl_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovl_ready_free: got %b, expected 1", ovl_ready);
    end
    push(500, 1'b1);
    step();
    ovl_valid = 1'b0;
    step();
  endtask

  task automatic test_range();
    cap_valid = 1'b1; cap_addr = AW'(DEPTH); cap_pixel = 1'b1;
    exp_drop = sat_inc(exp_drop);
    step();
    cap_valid = 1'b0;
    check_drop("drop_cap_oob");
    ovl_valid = 1'b1; ovl_addr = AW'(DEPTH); ovl_pixel = 1'b1;
    #1;
    n_checks++;
    if (ovl_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovl_ready_oob: got %b, expected 1", ovl_ready);
    end
    step();
    ovl_addr = AW'(DEPTH - 1);
    push(DEPTH - 1, 1'b1);
    step();
    ovl_valid = 1'b0;
    step();
    check_drop("drop_ovl_oob");
  endtask

  task automatic test_clear_restart();
    clear_req = 1'b1; cap_valid = 1'b1; cap_addr = AW'(3); ovl_valid = 1'b1;
    #1;
    n_checks++;
    if (ovl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_ready_clear: got %b, expected 0", ovl_ready);
    end
    exp_drop = sat_inc(exp_drop);
    step();
    clear_req = 1'b0; cap_valid = 1'b0; ovl_valid = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      clear_req = (i == 1000);
      push(i, CLEAR_VAL);
      step();
    end
    clear_req = 1'b0;
    go_normal(0);
    check_drop("drop_clear_req");
  endtask

  task automatic test_drop_sat();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cap_valid = 1'b1; cap_addr = AW'(7); cap_pixel = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(i, CLEAR_VAL);
      exp_drop = sat_inc(exp_drop);
      step();
    end
    cap_valid = 1'b0;
    check_drop("drop_saturated");
    go_normal(300);
    cap_valid = 1'b1; cap_addr = AW'(DEPTH);
    exp_drop = sat_inc(exp_drop);
    step();
    cap_valid = 1'b0;
    check_drop("drop_sat_hold");
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0; ovl_valid = 1'b1; ovl_addr = AW'(4);
    #1;
    n_checks++;
    if (ovl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_ready_in_reset: got %b, expected 0", ovl_ready);
    end
    cap_valid = 1'b1; cap_addr = AW'(9); cap_pixel = 1'b1;
    exp_drop = 0;
    step();
    check_drop("drop_reset");
    n_checks++;
    if (busy !== 1'b1 || waddr !== '0 || wdata !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b waddr=%0d wdata=%b, expected 1 0 0", busy, waddr, wdata);
    end
    reset_n = 1'b1; cap_valid = 1'b0; ovl_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(i, CLEAR_VAL);
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(i, CLEAR_VAL);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_clear_settle();
    test_capture();
    test_back_to_back();
    test_range();
    test_clear_restart();
    test_drop_sat();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
# fb_write_sched

Write-port scheduler for the 800-pixel-wide, 192000-entry frame buffer dual-port RAM. It shares the single RAM write port between three sources: the capture pixel stream from the Model 4 input monitor, a lower-priority overlay/status writer, and an internal clear engine. It also sequences the clear-then-resync procedure used at power-up and on 64/80-column mode changes. All outputs drive the RAM write port directly; the VGA read side is unaffected.

## Interface
- DEPTH, 192000, number of RAM words; the clear engine writes addresses 0..DEPTH-1
- AW, 18, write address width
- CLEAR_VAL, 1'b0, pixel value written by the clear engine
- dotclk  in  1  sole clock; all logic is on its rising edge
- reset_n  in  1  synchronous, active-low reset
- vsync  in  1  active-low vertical sync, already synchronised to dotclk
- clear_req  in  1  single-cycle pulse requesting a full clear, e.g. on a mode change
- cap_valid  in  1  capture pixel present this cycle; never stalled
- cap_addr  in  AW  capture write address
- cap_pixel  in  1  capture pixel value
- ovl_valid  in  1  overlay write request
- ovl_addr  in  AW  overlay write address
- ovl_pixel  in  1  overlay pixel value
- ovl_ready  out  1  overlay request accepted this cycle
- waddr  out  AW  RAM write address
- wdata  out  1  RAM write data
- wren  out  1  RAM write enable
- busy  out  1  high while in CLEAR or SETTLE
- drop_cnt  out  8  saturating count of capture pixels not written

## Operation
- States: CLEAR, SETTLE, NORMAL. Reset enters CLEAR with the clear counter at 0, so memory is always initialised after reset.
- CLEAR:
  - Each cycle: write clr_ctr with CLEAR_VAL, then increment clr_ctr.
  - After the cycle that writes DEPTH-1, go to SETTLE.
  - clear_req while in CLEAR restarts clr_ctr at 0 on the next cycle and stays in CLEAR.
- SETTLE:
  - No writes.
  - Wait for a vsync rising edge, detected internally from the vsync value registered on the previous cycle, then go to NORMAL. This makes capture resume on a frame boundary.
  - clear_req in SETTLE goes to CLEAR with clr_ctr = 0.
- NORMAL:
  - Priority is clear_req, then capture, then overlay.
  - clear_req: go to CLEAR with clr_ctr = 0. Any capture or overlay request in the same cycle is not written; the capture counts as dropped.
  - cap_valid with cap_addr < DEPTH: write cap_addr/cap_pixel.
  - cap_valid with cap_addr >= DEPTH: no write; counts as dropped.
  - ovl_ready = ovl_valid-independent, combinational: (state == NORMAL) & ~cap_valid & ~clear_req. An overlay transfer happens when ovl_valid & ovl_ready.
  - Overlay with ovl_addr >= DEPTH is accepted but not written; it is not counted.
- cap_valid in CLEAR or SETTLE: no write; counts as dropped.
- drop_cnt:
  - Increments by 1 per dropped capture and saturates at 255.
  - Cleared only by reset.
- busy = (state != NORMAL), registered alongside the state.

## Timing
- Write-port outputs are registered. A request accepted at edge N appears on waddr/wdata/wren from edge N+1 for exactly one cycle. wren is 0 in any cycle with no accepted write.
- Reset values: waddr = 0, wdata = 0, wren = 0, busy = 1, drop_cnt = 0. ovl_ready is 0 during reset.
- First edge with reset_n = 1: wren = 1, waddr = 0, wdata = CLEAR_VAL.
- A full clear produces DEPTH consecutive wren cycles with no gaps.
- The last clear write (address DEPTH-1) is on the output in the cycle the state register shows SETTLE.
- Writes from capture or overlay resume one cycle after NORMAL is entered.
- clr_ctr is never compared beyond DEPTH-1 and never wraps.
- reset_n low mid-clear or mid-write: next edge forces the reset values; no partial write is emitted.
- Simultaneous cap_valid and ovl_valid in NORMAL: capture wins and ovl_ready = 0. The overlay source holds its request.

## Test plan
- Reset, then release with vsync high. Expect 192000 consecutive writes at addresses 0..191999 with data 0, busy = 1. Then no writes until a vsync rising edge, after which busy = 0 on the following cycle.
- In NORMAL, cap_valid with addr 800 and pixel 1 at edge N. Expect waddr = 800, wdata = 1, wren = 1 in cycle N+1 only.
- cap_valid and ovl_valid both held for 3 cycles, then cap_valid low. Expect 3 capture writes, ovl_ready = 0 throughout, then one overlay write and ovl_ready = 1 in that cycle.
- clear_req pulsed at clr_ctr = 1000 during CLEAR. Expect the write sequence to restart at address 0, with 192000 more writes before SETTLE.
- 300 cap_valid cycles during CLEAR, plus 1 capture with cap_addr = 192000 in NORMAL. Expect drop_cnt = 255, saturated, with no capture writes.
- reset_n asserted for 1 cycle during NORMAL traffic. Expect wren = 0 and drop_cnt = 0 in the following cycle, then the clear restarts from address 0.
